jtdsp16_sio_rx: RTL

Serial input receiver for the DSP16 serial I/O unit, the receive-direction counterpart of the serial output path. It samples the asynchronous DI/ICK/ILD pins, deserialises 16- or 8-bit words, and delivers each word to the CPU-visible input buffer (SDX read side). It raises IBF, which feeds the interrupt logic. It sits beside the serial output block and shares the SIOC configuration bits with it.

---
 rtl/jtdsp16_sio_rx_if.sv | 18 +
 rtl/jtdsp16_sio_rx.sv | 89 ++++++++
 2 files changed

// File: rtl/jtdsp16_sio_rx_if.sv
// jtdsp16_sio_rx_if: serial input pins, SIOC config and SDX read-side bus of the SIO receiver.
interface jtdsp16_sio_rx_if;
    logic        cen;
    logic        di;
    logic        ick;
    logic        ild;
    logic        ilen;
    logic        msb;
    logic        sdx_read;
    logic [15:0] sdx_dout;
    logic        ibf;
    logic        ovf;
    logic [4:0]  debug_bitcnt;
    modport master (output cen, di, ick, ild, ilen, msb, sdx_read,
                    input  sdx_dout, ibf, ovf, debug_bitcnt);
    modport slave  (input  cen, di, ick, ild, ilen, msb, sdx_read,
                    output sdx_dout, ibf, ovf, debug_bitcnt);
endinterface

// File: rtl/jtdsp16_sio_rx.sv
// jtdsp16_sio_rx: DSP16 serial input receiver, deserialises DI on ICK rises into the SDX input buffer.
module jtdsp16_sio_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    jtdsp16_sio_rx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, XFER} state_t;
    state_t                  st, st_nx;
    logic [SYNC_STAGES-1:0]  di_s, ick_s, ild_s;
    logic                    ick_h, ild_h;
    logic                    di_q, ick_rise, ild_rise, rd;
    logic [15:0]             sr, sr_nx, sdx_dout;
    logic [4:0]              cnt, cnt_nx;
    logic                    w8, w8_nx, mf, mf_nx, ibf, ovf;

    assign di_q     = di_s[SYNC_STAGES-1];
    assign ick_rise = ick_s[SYNC_STAGES-1] & ~ick_h;
    assign ild_rise = ild_s[SYNC_STAGES-1] & ~ild_h;
    assign rd       = bus.sdx_read & bus.cen;
    assign bus.sdx_dout     = sdx_dout;
    assign bus.ibf          = ibf;
    assign bus.ovf          = ovf;
    assign bus.debug_bitcnt = cnt;

    // ILD has the last word: it restarts a word from any state, including XFER
    always_comb begin
        st_nx  = st;
        sr_nx  = sr;
        cnt_nx = cnt;
        w8_nx  = w8;
        mf_nx  = mf;
        if (st == XFER) begin
            st_nx  = IDLE;
            cnt_nx = 5'd0;
        end
        if (st == SHIFT && ick_rise) begin
            sr_nx  = mf ? {sr[14:0], di_q} : w8 ? {8'h00, di_q, sr[7:1]} : {di_q, sr[15:1]};
            cnt_nx = cnt + 5'd1;
            st_nx  = cnt_nx == (w8 ? 5'd8 : 5'd16) ? XFER : SHIFT;
        end
        if (ild_rise) begin
            st_nx  = SHIFT;
            sr_nx  = 16'h0;
            cnt_nx = 5'd0;
            w8_nx  = bus.ilen;
            mf_nx  = bus.msb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            di_s     <= '0;
            ick_s    <= '0;
            ild_s    <= '0;
            ick_h    <= 1'b0;
            ild_h    <= 1'b0;
            st       <= IDLE;
            sr       <= 16'h0;
            cnt      <= 5'd0;
            w8       <= 1'b0;
            mf       <= 1'b0;
            sdx_dout <= 16'h0;
            ibf      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            di_s  <= {di_s[SYNC_STAGES-2:0], bus.di};
            ick_s <= {ick_s[SYNC_STAGES-2:0], bus.ick};
            ild_s <= {ild_s[SYNC_STAGES-2:0], bus.ild};
            ick_h <= ick_s[SYNC_STAGES-1];
            ild_h <= ild_s[SYNC_STAGES-1];
            st    <= st_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            w8    <= w8_nx;
            mf    <= mf_nx;
            // a read colliding with XFER consumes the old word, so the new one stays flagged
            if (st == XFER) begin
                sdx_dout <= w8 ? {8'h00, sr[7:0]} : sr;
                ibf      <= 1'b1;
                ovf      <= ~rd & (ovf | ibf);
            end else if (rd) begin
                ibf <= 1'b0;
                ovf <= 1'b0;
            end
        end
    end
endmodule
